// File: rtl/mips_pkg.sv
// mips_pkg: MIPS opcode/funct constants, ALU op codes and register-0 constant.
// Build option: ID_EX_SLT_EN enables SLT decode (R-type funct 0x2A and slti).
// Without it, both decode as illegal for ALUs that return a constant on code 11.
package mips_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] F_ADD    = 6'h20;
    localparam logic [5:0] F_ADDU   = 6'h21;
    localparam logic [5:0] F_SUB    = 6'h22;
    localparam logic [5:0] F_SUBU   = 6'h23;
    localparam logic [5:0] F_AND    = 6'h24;
    localparam logic [5:0] F_OR     = 6'h25;
    localparam logic [5:0] F_SLT    = 6'h2A;
    localparam logic [4:0] REG_ZERO = 5'd0;
    // bit2 = invert B plus one, bits[1:0] = AND/OR/ADD/SLT
    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_t;
`ifdef ID_EX_SLT_EN
    localparam bit SLT_EN = 1'b1;
`else
    localparam bit SLT_EN = 1'b0;
`endif
endpackage

// File: rtl/alu_decode.sv
// alu_decode: combinational MIPS opcode/funct decode for the ID/EX stage.
// Build option: ID_EX_SLT_EN (via mips_pkg::SLT_EN) makes SLT/slti legal.
// Ports:
//   opcode, funct  in  instruction fields [31:26], [5:0]
//   rt, rd         in  register specifiers used for destination select
//   alu_op         out 3-bit ALU operation code
//   imm_sign       out 1 = sign-extend imm16, 0 = zero-extend
//   use_imm        out 1 = operand B is the immediate, 0 = rt value
//   dest           out destination register (rd for R-type, else rt)
//   reg_write, mem_read, mem_write, branch, illegal  out control flags
module alu_decode
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic [4:0] rt,
    input  logic [4:0] rd,
    output logic [2:0] alu_op,
    output logic       imm_sign,
    output logic       use_imm,
    output logic [4:0] dest,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       branch,
    output logic       illegal
);
    alu_op_t op;
    logic    rw;

    always_comb begin
        op        = ALU_ADD;
        imm_sign  = 1'b1;
        use_imm   = 1'b1;
        dest      = rt;
        rw        = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        branch    = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                use_imm = 1'b0;
                dest    = rd;
                rw      = 1'b1;
                case (funct)
                    F_ADD, F_ADDU: op = ALU_ADD;
                    F_SUB, F_SUBU: op = ALU_SUB;
                    F_AND:         op = ALU_AND;
                    F_OR:          op = ALU_OR;
                    F_SLT:         begin
                        op      = SLT_EN ? ALU_SLT : ALU_ADD;
                        rw      = SLT_EN;
                        illegal = !SLT_EN;
                    end
                    default:       begin
                        rw      = 1'b0;
                        illegal = 1'b1;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU: rw = 1'b1;
            OP_SLTI: begin
                op      = SLT_EN ? ALU_SLT : ALU_ADD;
                rw      = SLT_EN;
                illegal = !SLT_EN;
            end
            OP_ANDI: begin
                op       = ALU_AND;
                imm_sign = 1'b0;
                rw       = 1'b1;
            end
            OP_ORI: begin
                op       = ALU_OR;
                imm_sign = 1'b0;
                rw       = 1'b1;
            end
            OP_LW: begin
                rw       = 1'b1;
                mem_read = 1'b1;
            end
            OP_SW: mem_write = 1'b1;
            OP_BEQ: begin
                op      = ALU_SUB;
                use_imm = 1'b0;
                branch  = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        alu_op    = op;
        // writes to register 0 are architecturally discarded
        reg_write = rw && (dest != REG_ZERO);
    end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with decode, MEM/WB forwarding and
// valid/ready handshake feeding the EX-stage ALU.
// Build option: ID_EX_SLT_EN enables SLT/slti decode (else they are illegal).
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   in_valid / in_ready            ID-side handshake (in_ready = !ex_valid || ex_ready)
//   opcode, funct, rs, rt, rd, imm16, rs_data, rt_data   instruction and RF data
//   mem_fwd_en/rd/data, wb_fwd_en/rd/data                bypass sources
//   flush                          kills the registered instruction, drops input
//   ex_ready / ex_valid            EX-side handshake
//   ex_alu_op, ex_a, ex_b, ex_rd   ALU operands and destination
//   ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal  flags
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm16,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic              mem_fwd_en,
    input  logic [4:0]        mem_fwd_rd,
    input  logic [DATA_W-1:0] mem_fwd_data,
    input  logic              wb_fwd_en,
    input  logic [4:0]        wb_fwd_rd,
    input  logic [DATA_W-1:0] wb_fwd_data,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [2:0]        ex_alu_op,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [4:0]        ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_branch,
    output logic              ex_illegal
);
    logic [2:0]        alu_op;
    logic              imm_sign, use_imm, reg_write, mem_read, mem_write, branch, illegal;
    logic [4:0]        dest;
    logic [DATA_W-1:0] imm_ext, a_val, rt_val, b_val;

    alu_decode u_dec (
        .opcode    (opcode),
        .funct     (funct),
        .rt        (rt),
        .rd        (rd),
        .alu_op    (alu_op),
        .imm_sign  (imm_sign),
        .use_imm   (use_imm),
        .dest      (dest),
        .reg_write (reg_write),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .branch    (branch),
        .illegal   (illegal)
    );

    assign imm_ext = {{(DATA_W-16){imm_sign & imm16[15]}}, imm16};

    // MEM is the younger producer so it takes precedence over WB; r0 is never bypassed
    assign a_val  = (mem_fwd_en && mem_fwd_rd == rs && rs != REG_ZERO) ? mem_fwd_data :
                    (wb_fwd_en  && wb_fwd_rd  == rs && rs != REG_ZERO) ? wb_fwd_data  : rs_data;
    assign rt_val = (mem_fwd_en && mem_fwd_rd == rt && rt != REG_ZERO) ? mem_fwd_data :
                    (wb_fwd_en  && wb_fwd_rd  == rt && rt != REG_ZERO) ? wb_fwd_data  : rt_data;
    assign b_val  = use_imm ? imm_ext : rt_val;

    assign in_ready = !ex_valid || ex_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_alu_op    <= '0;
            ex_a         <= '0;
            ex_b         <= '0;
            ex_rd        <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_branch    <= 1'b0;
            ex_illegal   <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (in_ready) begin
            ex_valid <= in_valid;
            if (in_valid) begin
                ex_alu_op    <= alu_op;
                ex_a         <= a_val;
                ex_b         <= b_val;
                ex_rd        <= dest;
                ex_reg_write <= reg_write;
                ex_mem_read  <= mem_read;
                ex_mem_write <= mem_write;
                ex_branch    <= branch;
                ex_illegal   <= illegal;
            end
        end
    end
endmodule
